pc_npc_ctrl: RTL and testbench
==============================

Name: pc_npc_ctrl

Overview:
- Fetch-side program-counter unit directly downstream of the condition handler.
- Consumes the taken/not-taken decision for the branch in ID, and owns the PC/nPC pair for a delayed-branch ISA (one delay slot, annul bit).
- Drives the IF/ID squash and accepts a trap redirect.
- Sits between the condition handler / ID decode and the instruction memory address port.

Parameters:
- W, 32, address width.
- RESET_PC, 0, first fetched address after reset.
- INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- le  in  1  pipeline advance enable; 0 = stall, hold all state.
- id_valid  in  1  instruction in ID is live (not annulled/bubble).
- id_is_branch  in  1  ID holds a conditional/unconditional branch.
- id_is_jump  in  1  ID holds a register-indirect jump/call (always taken).
- id_annul  in  1  annul bit of branch in ID.
- id_cond_always  in  1  branch condition field is "always".
- br_taken  in  1  condition-handler decision for the branch in ID.
- br_target  in  W  PC-relative branch target.
- jmp_target  in  W  register-indirect target.
- trap_req  in  1  trap redirect request (highest priority).
- trap_vector  in  W  trap handler address.
- pc  out  W  current fetch address.
- npc  out  W  next fetch address.
- squash_if  out  1  instruction entering IF/ID this edge must become a bubble.
- squash_id  out  1  instruction in ID must become a bubble (trap only).
- redirect  out  1  nPC was loaded non-sequentially this cycle (debug/trace).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. On reset: pc=RESET_PC, npc=RESET_PC+INC, all outputs 0, FSM = RUN, annul_pend=0.
- Effective decisions:
  - take = id_valid & ((id_is_branch & br_taken) | id_is_jump).
  - annul_ds = id_valid & id_is_branch & id_annul & (~br_taken | id_cond_always).
  - Jumps never annul.
- Priority when le=1: trap_req, then take, then sequential.
- Update rules, le=1, no trap:
  - pc <= npc.
  - npc <= target if take, else npc+INC.
  - target = jmp_target when id_is_jump, else br_target.
  - redirect = take.
- Trap, le=1:
  - pc <= trap_vector; npc <= trap_vector+INC.
  - squash_if=1, squash_id=1 combinationally in that cycle.
  - Overrides any branch in ID.
- Squash timing:
  - squash_if is combinational: asserted in the same cycle annul_ds=1, so the delay-slot instruction in IF is replaced on that edge.
  - Zero added latency; the target fetch starts one cycle after the delay slot.
- Stall (le=0):
  - pc/npc hold.
  - If annul_ds or trap_req is asserted during a stall, latch annul_pend (or trap_pend with vector).
  - FSM goes RUN -> HOLD_SQ; the pending squash/redirect is applied on the first cycle with le=1, then back to RUN.
  - Live inputs in that cycle are ignored unless trap_req, which replaces a pending branch-annul.
- FSM states:
  - RUN: normal.
  - HOLD_SQ: squash/redirect pending under stall.
  - No other states.
- Arithmetic: W-bit, wrap-around modulo 2^W; npc+INC at all-ones wraps to INC-1 with no flag.
- Branch in the delay slot: the second branch is only honoured when id_valid=1. An annulled slot arrives with id_valid=0 and is ignored.
- Reset asserted mid-stall or with a pending squash clears all pending state and the FSM; reset wins over le and trap_req.
- Inputs with id_valid=0 produce no redirect and no squash.

Decomposition:
- Shared package: W default, RESET_PC, INC, FSM state encoding (RUN, HOLD_SQ), and the 4-bit cond code for "always" (shared with the condition handler so id_cond_always is derived consistently in decode).
- One natural sub-module: pc_pair_reg (PC/nPC registers with load-enable, sequential increment and redirect mux).
- Squash/pending FSM stays in the top.

Test Plan:
- Reset: hold reset 2 cycles, release with le=1 and no branches -> pc sequence 0,4,8,12; npc always pc+4; squash_if=0.
- Taken conditional, no annul: branch at pc=0x10, br_taken=1, br_target=0x100, id_annul=0 -> pc goes 0x14 (delay slot executes), then 0x100; squash_if=0; redirect=1 for one cycle.
- Untaken with annul: id_annul=1, br_taken=0 -> squash_if=1 same cycle; pc continues 0x14, 0x18; delay slot becomes bubble.
- Branch-always with annul: id_cond_always=1, br_taken=1, id_annul=1, target 0x200 -> squash_if=1; next pcs 0x14 (bubbled), 0x200.
- Stall with pending annul: annul_ds=1 while le=0 for 3 cycles -> pc/npc frozen, FSM=HOLD_SQ; squash_if fires on first le=1 cycle, then FSM=RUN.
- Trap over branch: trap_req=1, trap_vector=0x80 together with taken branch to 0x300 -> pc=0x80, npc=0x84; squash_if=squash_id=1; branch target never fetched.

Source files
------------

// File: rtl/pc_npc_ctrl_pkg.sv
// Shared definitions for the fetch-side PC/nPC unit and its neighbours in decode
// and the condition handler.
package pc_npc_ctrl_pkg;

    localparam int unsigned PC_W         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned INC_DEF      = 4;

    // Condition field value meaning "branch always"
    localparam logic [3:0]  COND_ALWAYS  = 4'b1000;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_HOLD_SQ = 1'b1
    } pc_state_e;

    function automatic logic is_cond_always(input logic [3:0] cond);
        return cond == COND_ALWAYS;
    endfunction

endpackage

// File: rtl/pc_npc_ctrl_pc_pair.sv
// PC/nPC register pair: advances on adv, loading a trap vector, a branch
// target or the sequential successor.
module pc_pair_reg
    import pc_npc_ctrl_pkg::*;
#(
    parameter int unsigned  W        = PC_W,
    parameter logic [W-1:0] RESET_PC = W'(RESET_PC_DEF),
    parameter int unsigned  INC      = INC_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    input  logic         load_vec,
    input  logic [W-1:0] vec,
    input  logic         load_tgt,
    input  logic [W-1:0] tgt,
    output logic [W-1:0] pc,
    output logic [W-1:0] npc
);

    localparam logic [W-1:0] INC_W = W'(INC);

    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] npc_q, npc_d;

    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (adv) begin
            if (load_vec) begin
                pc_d  = vec;
                npc_d = vec + INC_W;
            end else begin
                pc_d  = npc_q;
                npc_d = load_tgt ? tgt : npc_q + INC_W;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            npc_q <= RESET_PC + INC_W;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign pc  = pc_q;
    assign npc = npc_q;

endmodule

// File: rtl/pc_npc_ctrl.sv
// Delayed-branch PC/nPC controller: branch/jump redirect, delay-slot annul
// squash, trap redirect, and squash/trap pending across pipeline stalls.
module pc_npc_ctrl
    import pc_npc_ctrl_pkg::*;
#(
    parameter int unsigned  W        = PC_W,
    parameter logic [W-1:0] RESET_PC = W'(RESET_PC_DEF),
    parameter int unsigned  INC      = INC_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         le,
    input  logic         id_valid,
    input  logic         id_is_branch,
    input  logic         id_is_jump,
    input  logic         id_annul,
    input  logic         id_cond_always,
    input  logic         br_taken,
    input  logic [W-1:0] br_target,
    input  logic [W-1:0] jmp_target,
    input  logic         trap_req,
    input  logic [W-1:0] trap_vector,
    output logic [W-1:0] pc,
    output logic [W-1:0] npc,
    output logic         squash_if,
    output logic         squash_id,
    output logic         redirect
);

    logic         take;
    logic         annul_ds;
    logic [W-1:0] target;

    pc_state_e    state_q, state_d;
    logic         annul_pend_q, annul_pend_d;
    logic         trap_pend_q, trap_pend_d;
    logic [W-1:0] trap_vec_q, trap_vec_d;

    logic         do_trap;
    logic         do_take;
    logic         sq_if;
    logic         sq_id;
    logic [W-1:0] trap_addr;

    always_comb begin
        take     = id_valid & ((id_is_branch & br_taken) | id_is_jump);
        annul_ds = id_valid & id_is_branch & ~id_is_jump & id_annul
                   & (~br_taken | id_cond_always);
        target   = id_is_jump ? jmp_target : br_target;
    end

    always_comb begin
        state_d      = state_q;
        annul_pend_d = annul_pend_q;
        trap_pend_d  = trap_pend_q;
        trap_vec_d   = trap_vec_q;
        do_trap      = 1'b0;
        do_take      = 1'b0;
        sq_if        = 1'b0;
        sq_id        = 1'b0;
        trap_addr    = trap_vector;

        if (le) begin
            state_d      = ST_RUN;
            annul_pend_d = 1'b0;
            trap_pend_d  = 1'b0;
            if (trap_req) begin
                do_trap = 1'b1;
            end else if (state_q == ST_HOLD_SQ) begin
                // Resuming from a stall: only the latched event acts, live ID is ignored
                if (trap_pend_q) begin
                    do_trap   = 1'b1;
                    trap_addr = trap_vec_q;
                end else begin
                    sq_if = annul_pend_q;
                end
            end else begin
                do_take = take;
                sq_if   = annul_ds;
            end
            if (do_trap) begin
                sq_if = 1'b1;
                sq_id = 1'b1;
            end
        end else begin
            if (trap_req) begin
                state_d      = ST_HOLD_SQ;
                trap_pend_d  = 1'b1;
                trap_vec_d   = trap_vector;
                annul_pend_d = 1'b0;
            end else if (annul_ds && !trap_pend_q) begin
                state_d      = ST_HOLD_SQ;
                annul_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            annul_pend_q <= 1'b0;
            trap_pend_q  <= 1'b0;
            trap_vec_q   <= '0;
        end else begin
            state_q      <= state_d;
            annul_pend_q <= annul_pend_d;
            trap_pend_q  <= trap_pend_d;
            trap_vec_q   <= trap_vec_d;
        end
    end

    always_comb begin
        squash_if = sq_if & ~reset;
        squash_id = sq_id & ~reset;
        redirect  = (do_trap | do_take) & ~reset;
    end

    pc_pair_reg #(
        .W        (W),
        .RESET_PC (RESET_PC),
        .INC      (INC)
    ) u_pc_pair (
        .clk      (clk),
        .reset    (reset),
        .adv      (le),
        .load_vec (do_trap),
        .vec      (trap_addr),
        .load_tgt (do_take),
        .tgt      (target),
        .pc       (pc),
        .npc      (npc)
    );

endmodule

// File: tb/tb_pc_npc_ctrl.sv
// Self-checking bench for pc_npc_ctrl: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model of the PC/nPC rules.
module tb_pc_npc_ctrl;

    logic        clk = 1'b0;
    logic        reset, le, id_valid, id_is_branch, id_is_jump, id_annul;
    logic        id_cond_always, br_taken, trap_req;
    logic [31:0] br_target, jmp_target, trap_vector;
    logic [31:0] pc, npc;
    logic        squash_if, squash_id, redirect;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_npc_ctrl #(.W(32), .RESET_PC(32'h0), .INC(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .le             (le),
        .id_valid       (id_valid),
        .id_is_branch   (id_is_branch),
        .id_is_jump     (id_is_jump),
        .id_annul       (id_annul),
        .id_cond_always (id_cond_always),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .jmp_target     (jmp_target),
        .trap_req       (trap_req),
        .trap_vector    (trap_vector),
        .pc             (pc),
        .npc            (npc),
        .squash_if      (squash_if),
        .squash_id      (squash_id),
        .redirect       (redirect)
    );

    typedef struct {
        bit          rst, le, v, br, jmp, an, alw, tk, trap;
        logic [31:0] bt, jt, tv;
    } stim_t;

    // Model: architectural PC pair plus what is owed after a stall
    // (0 = nothing, 1 = delay-slot squash, 2 = trap to m_vec).
    logic [31:0] m_pc, m_npc, m_vec;
    int          m_pend = 0;
    bit          m_known = 0;

    logic [31:0] e_pc, e_npc, o_pc, o_npc;
    logic        e_sqif, e_sqid, e_red, o_sqif, o_sqid, o_red;
    bit          e_known;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.le = 1; s.v = 0; s.br = 0; s.jmp = 0; s.an = 0;
        s.alw = 0; s.tk = 0; s.trap = 0;
        s.bt = '0; s.jt = '0; s.tv = '0;
        return s;
    endfunction

    // One clock: drive, predict, sample at the falling edge, commit the model.
    task automatic cyc(input stim_t s);
        logic [31:0] n_pc, n_npc, n_vec, tv;
        int          n_pend;
        bit          tk, an, trap_now;
        @(posedge clk); #1;
        reset = s.rst; le = s.le; id_valid = s.v; id_is_branch = s.br;
        id_is_jump = s.jmp; id_annul = s.an; id_cond_always = s.alw;
        br_taken = s.tk; br_target = s.bt; jmp_target = s.jt;
        trap_req = s.trap; trap_vector = s.tv;

        tk = s.v && ((s.br && s.tk) || s.jmp);
        an = s.v && s.br && !s.jmp && s.an && (!s.tk || s.alw);
        e_pc = m_pc; e_npc = m_npc; e_known = m_known;
        e_sqif = 0; e_sqid = 0; e_red = 0;
        n_pc = m_pc; n_npc = m_npc; n_vec = m_vec; n_pend = m_pend;
        trap_now = 0; tv = s.tv;
        if (s.rst) begin
            n_pc = 32'h0; n_npc = 32'h4; n_pend = 0;
        end else if (s.le) begin
            n_pend = 0;
            if (s.trap) trap_now = 1;
            else if (m_pend == 2) begin trap_now = 1; tv = m_vec; end
            else if (m_pend == 1) begin
                e_sqif = 1; n_pc = m_npc; n_npc = m_npc + 32'd4;
            end else begin
                n_pc = m_npc;
                n_npc = tk ? (s.jmp ? s.jt : s.bt) : m_npc + 32'd4;
                e_sqif = an; e_red = tk;
            end
            if (trap_now) begin
                n_pc = tv; n_npc = tv + 32'd4;
                e_sqif = 1; e_sqid = 1; e_red = 1;
            end
        end else begin
            if (s.trap) begin n_pend = 2; n_vec = s.tv; end
            else if (an && m_pend != 2) n_pend = 1;
        end

        @(negedge clk);
        o_pc = pc; o_npc = npc; o_sqif = squash_if; o_sqid = squash_id; o_red = redirect;
        m_pc = n_pc; m_npc = n_npc; m_vec = n_vec; m_pend = n_pend;
        if (s.rst) m_known = 1;
    endtask

    task automatic reset_to(input int unsigned n);
        stim_t s;
        s = idle(); s.rst = 1;
        cyc(s);
        s.rst = 0;
        for (int unsigned i = 0; i < n; i++) cyc(s);
    endtask

    task automatic test_reset();
        stim_t s;
        for (int i = 0; i < 6; i++) begin
            s = idle();
            if (i < 2) begin
                s.rst = 1; s.trap = 1; s.tv = 32'h80;
                s.v = 1; s.br = 1; s.an = 1; s.tk = 1; s.alw = 1; s.bt = 32'h300;
            end
            cyc(s);
            checks++;
            if (e_known ? ({o_pc, o_npc, o_sqif, o_sqid, o_red} !== {e_pc, e_npc, e_sqif, e_sqid, e_red})
                        : ({o_sqif, o_sqid, o_red} !== {e_sqif, e_sqid, e_red})) begin
                errors++;
                $display("FAIL reset[%0d]: got pc=%h npc=%h sq_if=%b sq_id=%b red=%b, expected pc=%h npc=%h sq_if=%b sq_id=%b red=%b",
                         i, o_pc, o_npc, o_sqif, o_sqid, o_red, e_pc, e_npc, e_sqif, e_sqid, e_red);
            end
            if (i >= 2) begin
                checks++;
                if (o_pc !== 32'((i - 2) * 4) || o_npc !== 32'((i - 1) * 4) || o_sqif !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_seq[%0d]: got pc=%h npc=%h sq_if=%b, expected pc=%h npc=%h sq_if=0",
                             i, o_pc, o_npc, o_sqif, 32'((i - 2) * 4), 32'((i - 1) * 4));
                end
            end
        end
    endtask

    // Branch presented while pc=0x10; columns: taken, annul, always, target.
    task automatic test_branch(input string name, input bit tk, input bit an, input bit alw,
                               input logic [31:0] tgt, input logic [31:0] pc2, input bit want_sq);
        stim_t s;
        logic [31:0] want_pc [3];
        want_pc[0] = 32'h10; want_pc[1] = 32'h14; want_pc[2] = pc2;
        reset_to(4);
        for (int i = 0; i < 3; i++) begin
            s = idle();
            if (i == 0) begin
                s.v = 1; s.br = 1; s.tk = tk; s.an = an; s.alw = alw; s.bt = tgt;
                s.jt = 32'hDEAD_0000;
            end
            cyc(s);
            checks++;
            if ({o_pc, o_npc, o_sqif, o_sqid, o_red} !== {e_pc, e_npc, e_sqif, e_sqid, e_red}) begin
                errors++;
                $display("FAIL %s[%0d]: got pc=%h npc=%h sq_if=%b sq_id=%b red=%b, expected pc=%h npc=%h sq_if=%b sq_id=%b red=%b",
                         name, i, o_pc, o_npc, o_sqif, o_sqid, o_red, e_pc, e_npc, e_sqif, e_sqid, e_red);
            end
            checks++;
            if (o_pc !== want_pc[i] || o_sqif !== (i == 0 && want_sq) || o_red !== (i == 0 && tk)) begin
                errors++;
                $display("FAIL %s_seq[%0d]: got pc=%h sq_if=%b red=%b, expected pc=%h sq_if=%b red=%b",
                         name, i, o_pc, o_sqif, o_red, want_pc[i], (i == 0 && want_sq), (i == 0 && tk));
            end
        end
    endtask

    task automatic test_stall_annul();
        stim_t s;
        logic [31:0] want_pc [6];
        bit          want_sq [6];
        want_pc = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h14, 32'h18};
        want_sq = '{0, 0, 0, 1, 0, 0};
        reset_to(4);
        for (int i = 0; i < 6; i++) begin
            s = idle();
            if (i < 3) begin s.le = 0; s.v = 1; s.br = 1; s.an = 1; s.tk = 0; end
            if (i == 3) begin s.v = 1; s.br = 1; s.tk = 1; s.bt = 32'h500; end
            cyc(s);
            checks++;
            if ({o_pc, o_npc, o_sqif, o_sqid, o_red} !== {e_pc, e_npc, e_sqif, e_sqid, e_red}) begin
                errors++;
                $display("FAIL stall_annul[%0d]: got pc=%h npc=%h sq_if=%b sq_id=%b red=%b, expected pc=%h npc=%h sq_if=%b sq_id=%b red=%b",
                         i, o_pc, o_npc, o_sqif, o_sqid, o_red, e_pc, e_npc, e_sqif, e_sqid, e_red);
            end
            checks++;
            if (o_pc !== want_pc[i] || o_sqif !== want_sq[i]) begin
                errors++;
                $display("FAIL stall_annul_seq[%0d]: got pc=%h sq_if=%b, expected pc=%h sq_if=%b",
                         i, o_pc, o_sqif, want_pc[i], want_sq[i]);
            end
        end
    endtask

    // Trap over a taken branch, then vector wrap-around at the top of the space.
    task automatic test_trap();
        stim_t s;
        logic [31:0] vec [3];
        logic [31:0] want_npc [3];
        vec = '{32'h80, 32'hFFFF_FFFC, 32'hFFFF_FFFF};
        want_npc = '{32'h84, 32'h0, 32'h3};
        for (int t = 0; t < 3; t++) begin
            reset_to(4);
            for (int i = 0; i < 3; i++) begin
                s = idle();
                if (i == 0) begin
                    s.trap = 1; s.tv = vec[t];
                    s.v = 1; s.br = 1; s.tk = 1; s.bt = 32'h300;
                end
                cyc(s);
                checks++;
                if ({o_pc, o_npc, o_sqif, o_sqid, o_red} !== {e_pc, e_npc, e_sqif, e_sqid, e_red}) begin
                    errors++;
                    $display("FAIL trap%0d[%0d]: got pc=%h npc=%h sq_if=%b sq_id=%b red=%b, expected pc=%h npc=%h sq_if=%b sq_id=%b red=%b",
                             t, i, o_pc, o_npc, o_sqif, o_sqid, o_red, e_pc, e_npc, e_sqif, e_sqid, e_red);
                end
                if (i == 1) begin
                    checks++;
                    if (o_pc !== vec[t] || o_npc !== want_npc[t]) begin
                        errors++;
                        $display("FAIL trap%0d_vec: got pc=%h npc=%h, expected pc=%h npc=%h",
                                 t, o_pc, o_npc, vec[t], want_npc[t]);
                    end
                end
            end
        end
    endtask

    // Trap replacing a pending annul under stall, live trap overriding a pending one,
    // reset clearing pending state, and id_valid=0 inputs.
    task automatic test_pending_mix();
        stim_t s;
        stim_t seq [14];
        for (int i = 0; i < 14; i++) seq[i] = idle();
        seq[0].le = 0; seq[0].v = 1; seq[0].br = 1; seq[0].an = 1;
        seq[1].le = 0; seq[1].trap = 1; seq[1].tv = 32'h40;
        seq[3].le = 0; seq[3].trap = 1; seq[3].tv = 32'h60;
        seq[4].trap = 1; seq[4].tv = 32'h70;
        seq[6].le = 0; seq[6].v = 1; seq[6].br = 1; seq[6].an = 1;
        seq[7].le = 0; seq[7].trap = 1; seq[7].tv = 32'h90;
        seq[8].rst = 1; seq[8].le = 0; seq[8].trap = 1; seq[8].tv = 32'hA0;
        seq[10].v = 0; seq[10].br = 1; seq[10].tk = 1; seq[10].an = 1; seq[10].bt = 32'h400;
        seq[11].v = 0; seq[11].jmp = 1; seq[11].jt = 32'h800;
        seq[12].v = 1; seq[12].jmp = 1; seq[12].jt = 32'h800; seq[12].an = 1; seq[12].br = 1;
        reset_to(2);
        for (int i = 0; i < 14; i++) begin
            s = seq[i];
            cyc(s);
            checks++;
            if ({o_pc, o_npc, o_sqif, o_sqid, o_red} !== {e_pc, e_npc, e_sqif, e_sqid, e_red}) begin
                errors++;
                $display("FAIL pending[%0d]: got pc=%h npc=%h sq_if=%b sq_id=%b red=%b, expected pc=%h npc=%h sq_if=%b sq_id=%b red=%b",
                         i, o_pc, o_npc, o_sqif, o_sqid, o_red, e_pc, e_npc, e_sqif, e_sqid, e_red);
            end
        end
    endtask

    task automatic test_random();
        stim_t s;
        reset_to(1);
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.rst  = ($urandom_range(0, 79) == 0);
            s.le   = ($urandom_range(0, 3) != 0);
            s.v    = ($urandom_range(0, 3) != 0);
            s.br   = $urandom_range(0, 1) == 1;
            s.jmp  = ($urandom_range(0, 5) == 0);
            s.an   = $urandom_range(0, 1) == 1;
            s.alw  = $urandom_range(0, 1) == 1;
            s.tk   = $urandom_range(0, 1) == 1;
            s.trap = ($urandom_range(0, 15) == 0);
            s.bt   = $urandom & 32'hFFFF_FFFC;
            s.jt   = $urandom & 32'hFFFF_FFFC;
            s.tv   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFF0);
            cyc(s);
            checks++;
            if ({o_pc, o_npc, o_sqif, o_sqid, o_red} !== {e_pc, e_npc, e_sqif, e_sqid, e_red}) begin
                errors++;
                $display("FAIL random[%0d]: got pc=%h npc=%h sq_if=%b sq_id=%b red=%b, expected pc=%h npc=%h sq_if=%b sq_id=%b red=%b",
                         i, o_pc, o_npc, o_sqif, o_sqid, o_red, e_pc, e_npc, e_sqif, e_sqid, e_red);
            end
        end
    endtask

    initial begin
        reset = 1; le = 0; id_valid = 0; id_is_branch = 0; id_is_jump = 0;
        id_annul = 0; id_cond_always = 0; br_taken = 0; trap_req = 0;
        br_target = '0; jmp_target = '0; trap_vector = '0;
        test_reset();
        test_branch("taken",        1'b1, 1'b0, 1'b0, 32'h100, 32'h100, 1'b0);
        test_branch("untaken_annul", 1'b0, 1'b1, 1'b0, 32'h100, 32'h18,  1'b1);
        test_branch("always_annul", 1'b1, 1'b1, 1'b1, 32'h200, 32'h200, 1'b1);
        test_branch("taken_annul",  1'b1, 1'b1, 1'b0, 32'h240, 32'h240, 1'b0);
        test_stall_annul();
        test_trap();
        test_pending_mix();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
